// File: rtl/pll_lock_ctrl.sv
// PLL power-up / lock sequencer: walks pllen and PLL resetn, filters lock with a
// timeout/retry policy, then gates clock outputs and releases the downstream reset.
module pll_lock_ctrl #(
  parameter int         PWRUP_CYCLES   = 16,
  parameter int         RST_CYCLES     = 32,
  parameter int         LOCK_FILTER    = 64,
  parameter int         LOCK_TIMEOUT   = 65535,
  parameter int         MAX_RETRY      = 3,
  parameter logic [3:0] CLKOUT_EN_MASK = 4'b0011,
  parameter int         RELEASE_DLY    = 4
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pllen,
  output logic       pll_resetn,
  output logic [3:0] clkout_en,
  output logic       sys_rstn,
  output logic       locked,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  // state     | meaning
  // ----------+--------------------------------------------------------------
  // OFF       | PLL disabled, waiting PWRUP_CYCLES after reset release
  // PRST      | PLL enabled, held in reset for RST_CYCLES
  // WAIT_LOCK | PLL running, waiting for synchronised lock (with timeout)
  // FILTER    | lock seen, requiring LOCK_FILTER consecutive lock-high cycles
  // RUN       | outputs enabled, sys_rstn released after RELEASE_DLY cycles
  // FAIL      | retries exhausted, PLL off until relock_req or reset
  typedef enum logic [2:0] {
    S_OFF, S_PRST, S_WAIT_LOCK, S_FILTER, S_RUN, S_FAIL
  } state_t;

  localparam int M1 = (PWRUP_CYCLES > RST_CYCLES) ? PWRUP_CYCLES : RST_CYCLES;
  localparam int M2 = (M1 > LOCK_FILTER) ? M1 : LOCK_FILTER;
  localparam int M3 = (M2 > LOCK_TIMEOUT) ? M2 : LOCK_TIMEOUT;
  localparam int M4 = (M3 > RELEASE_DLY) ? M3 : RELEASE_DLY;
  localparam int CW = $clog2(M4 + 1);

  localparam logic [CW-1:0] PWRUP_LAST   = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_DLY - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRY);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lk_m;
  logic          lk_s;
  logic [1:0]    retry_inc;

  assign retry_inc = retry_cnt + 2'd1;

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state      <= S_OFF;
      cnt        <= '0;
      lk_m       <= 1'b0;
      lk_s       <= 1'b0;
      pllen      <= 1'b0;
      pll_resetn <= 1'b0;
      clkout_en  <= 4'b0000;
      sys_rstn   <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      retry_cnt  <= 2'd0;
    end else begin
      lk_m <= pll_lock;
      lk_s <= lk_m;
      case (state)
        S_OFF: begin
          if (cnt == PWRUP_LAST) begin
            state <= S_PRST;
            cnt   <= '0;
            pllen <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRST: begin
          if (cnt == RST_LAST) begin
            state      <= S_WAIT_LOCK;
            cnt        <= '0;
            pll_resetn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // the lock cycle that triggers FILTER already counts toward the filter
          if (lk_s) begin
            state <= S_FILTER;
            cnt   <= CNT_ONE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt        <= '0;
            retry_cnt  <= retry_inc;
            pll_resetn <= 1'b0;
            if (retry_inc == RETRY_LIMIT) begin
              state <= S_FAIL;
              pllen <= 1'b0;
              fail  <= 1'b1;
            end else begin
              state <= S_PRST;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FILTER: begin
          if (!lk_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == FILTER_LAST) begin
            state     <= S_RUN;
            cnt       <= '0;
            clkout_en <= CLKOUT_EN_MASK;
            locked    <= 1'b1;
            retry_cnt <= 2'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (relock_req || !lk_s) begin
            state      <= S_PRST;
            cnt        <= '0;
            pll_resetn <= 1'b0;
            clkout_en  <= 4'b0000;
            locked     <= 1'b0;
            sys_rstn   <= 1'b0;
            retry_cnt  <= 2'd0;
          end else if (cnt == RELEASE_LAST) begin
            sys_rstn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FAIL: begin
          if (relock_req) begin
            state     <= S_PRST;
            cnt       <= '0;
            pllen     <= 1'b1;
            fail      <= 1'b0;
            retry_cnt <= 2'd0;
          end
        end
        default: begin
          state      <= S_OFF;
          cnt        <= '0;
          pllen      <= 1'b0;
          pll_resetn <= 1'b0;
          clkout_en  <= 4'b0000;
          sys_rstn   <= 1'b0;
          locked     <= 1'b0;
          fail       <= 1'b0;
          retry_cnt  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Power-up and lock sequencer that sits directly upstream of the alta_pllx PLL wrapper and drives its pllen, resetn and clkoutNen inputs. It consumes the PLL lock output and qualifies it with a filter and a timeout/retry policy. It then releases a clean synchronous system reset (sys_rstn) to the logic clocked by the PLL outputs. It runs on the PLL reference clock, the internal oscillator feeding clkin.

Parameters:
PWRUP_CYCLES, 16, cycles pllen held low after reset release
RST_CYCLES, 32, cycles PLL resetn held low after pllen asserted
LOCK_FILTER, 64, consecutive synchronised-lock-high cycles required before RUN
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK per attempt
MAX_RETRY, 3, failed attempts before FAIL
CLKOUT_EN_MASK, 4'b0011, clkoutNen value driven in RUN
RELEASE_DLY, 4, cycles in RUN before sys_rstn deasserts

Ports:
clkin  in  1  reference clock, same net as PLL clkin
resetn  in  1  synchronous active-low reset
pll_lock  in  1  PLL lock, asynchronous to clkin
relock_req  in  1  single-cycle request to restart the sequence
pllen  out  1  to PLL pllen
pll_resetn  out  1  to PLL resetn
clkout_en  out  4  to PLL clkout3en..clkout0en
sys_rstn  out  1  active-low reset for downstream logic
locked  out  1  qualified lock status
fail  out  1  retries exhausted
retry_cnt  out  2  failed attempts in current sequence

Behaviour:
- Clocking and reset: one clock, clkin. resetn is synchronous and active-low. All outputs are registered.
- Reset values while resetn=0: state=OFF, pllen=0, pll_resetn=0, clkout_en=0, sys_rstn=0, locked=0, fail=0, retry_cnt=0, all counters 0, synchroniser flops 0.
- Lock synchroniser: pll_lock passes through a 2-flop synchroniser to give lk_s, adding 2 cycles of latency. Only lk_s is used.
- Single counter cnt: cleared on every state entry. Width is sized for the largest parameter.
- OFF: pllen=0, pll_resetn=0. After PWRUP_CYCLES cycles -> PRST.
- PRST: pllen=1, pll_resetn=0. After RST_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: pllen=1, pll_resetn=1.
  - lk_s=1 -> FILTER.
  - cnt reaches LOCK_TIMEOUT -> retry_cnt+1. If the new value equals MAX_RETRY -> FAIL, else -> PRST.
- FILTER: cnt counts lk_s=1 cycles.
  - Any lk_s=0 -> WAIT_LOCK; the timeout count restarts at 0.
  - cnt reaches LOCK_FILTER -> RUN.
- RUN: clkout_en=CLKOUT_EN_MASK and locked=1 from the first RUN cycle. sys_rstn=1 once RELEASE_DLY cycles have elapsed in RUN. retry_cnt is cleared on entry.
- Lock loss in RUN: lk_s=0 for a single cycle is enough. The next cycle gives clkout_en=0, locked=0, sys_rstn=0, state=PRST, retry_cnt=0.
- FAIL: pllen=0, pll_resetn=0, clkout_en=0, sys_rstn=0, fail=1. Exits only on relock_req or resetn.
- relock_req:
  - In RUN or FAIL -> PRST. fail=0, retry_cnt=0, sys_rstn=0 and clkout_en=0 on the next cycle.
  - Ignored in OFF, PRST, WAIT_LOCK and FILTER.
- Simultaneous events in RUN: if relock_req and a lock drop occur in the same cycle, the result is identical (PRST).
- resetn low mid-sequence: all outputs return to their reset values on the next edge, regardless of state.
- Invariant: sys_rstn=1 implies locked=1 and clkout_en=CLKOUT_EN_MASK.
- Invariant: pll_resetn=1 implies pllen=1.

Test Plan:
Test parameters: PWRUP=4, RST=8, LOCK_FILTER=16, LOCK_TIMEOUT=100, MAX_RETRY=2, RELEASE_DLY=4. Cycle 0 is the first edge with resetn=1.
1. Nominal lock: pll_lock rises at cycle 20 and stays high. Required: pllen=1 at cycle 4, pll_resetn=1 at cycle 12, locked=1 and clkout_en=4'b0011 at cycle 38, sys_rstn=1 at cycle 42, retry_cnt=0.
2. Glitchy lock: pll_lock high for 10 cycles, low for 1, then high. Required: FILTER aborts with locked=0 throughout, RUN is entered 16 clean cycles after the final rise plus 2 sync cycles.
3. Timeout/fail: pll_lock held 0. Required: retry_cnt=1 after the first timeout and PRST is re-entered. After the second timeout fail=1, pllen=0, retry_cnt=2. State holds for 1000 cycles.
4. Lock loss in RUN: drop pll_lock for 1 cycle. Required: 3 cycles later (2 sync + 1) sys_rstn=0, locked=0, clkout_en=0, pll_resetn=0 for 8 cycles. Re-lock completes and sys_rstn returns to 1.
5. relock_req: pulse in FAIL -> fail=0, PRST. Pulse during WAIT_LOCK -> no effect. Pulse in RUN -> sys_rstn=0 on the next cycle.
6. Reset mid-FILTER: resetn=0 for 1 cycle -> all outputs at reset values on the next cycle and the sequence restarts from OFF.
